ex: RTL

Execute stage of the five-stage MIPS32 pipeline. Consumes the registered decode results (operation, category, operands, destination) and produces the write-back value for the EX/MEM register. Covers logic, shift, add/subtract/compare and HI/LO moves combinationally. DIV/DIVU run on an iterative radix-2 divider that stalls the front of the pipeline until the quotient and remainder are ready.

---
 rtl/ex_pkg.sv | 51 +++++
 rtl/ex_div.sv | 122 ++++++++++++
 rtl/ex.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/ex_pkg.sv
// Shared encodings for the MIPS32 execute stage: opcodes, result categories,
// common constants and the divider state type.
package ex_pkg;

  localparam int RegBus     = 32;
  localparam int RegAddrBus = 5;
  localparam int AluOpBus   = 8;
  localparam int AluSelBus  = 3;

  localparam logic [RegBus-1:0]     ZeroWord      = 32'h0000_0000;
  localparam logic [RegAddrBus-1:0] NOPRegAddr    = 5'b00000;
  localparam logic                  WriteEnable   = 1'b1;
  localparam logic                  WriteDisable  = 1'b0;
  localparam logic                  StallRequest  = 1'b1;
  localparam logic                  NoStop        = 1'b0;

  localparam logic [AluOpBus-1:0] EXE_NOP_OP   = 8'b0000_0000;
  localparam logic [AluOpBus-1:0] EXE_AND_OP   = 8'b0010_0100;
  localparam logic [AluOpBus-1:0] EXE_OR_OP    = 8'b0010_0101;
  localparam logic [AluOpBus-1:0] EXE_XOR_OP   = 8'b0010_0110;
  localparam logic [AluOpBus-1:0] EXE_NOR_OP   = 8'b0010_0111;
  localparam logic [AluOpBus-1:0] EXE_SLL_OP   = 8'b0111_1100;
  localparam logic [AluOpBus-1:0] EXE_SRL_OP   = 8'b0000_0010;
  localparam logic [AluOpBus-1:0] EXE_SRA_OP   = 8'b0000_0011;
  localparam logic [AluOpBus-1:0] EXE_SLT_OP   = 8'b0010_1010;
  localparam logic [AluOpBus-1:0] EXE_SLTU_OP  = 8'b0010_1011;
  localparam logic [AluOpBus-1:0] EXE_ADD_OP   = 8'b0010_0000;
  localparam logic [AluOpBus-1:0] EXE_ADDU_OP  = 8'b0010_0001;
  localparam logic [AluOpBus-1:0] EXE_SUB_OP   = 8'b0010_0010;
  localparam logic [AluOpBus-1:0] EXE_SUBU_OP  = 8'b0010_0011;
  localparam logic [AluOpBus-1:0] EXE_MFHI_OP  = 8'b0001_0000;
  localparam logic [AluOpBus-1:0] EXE_MTHI_OP  = 8'b0001_0001;
  localparam logic [AluOpBus-1:0] EXE_MFLO_OP  = 8'b0001_0010;
  localparam logic [AluOpBus-1:0] EXE_MTLO_OP  = 8'b0001_0011;
  localparam logic [AluOpBus-1:0] EXE_DIV_OP   = 8'b0001_1010;
  localparam logic [AluOpBus-1:0] EXE_DIVU_OP  = 8'b0001_1011;

  localparam logic [AluSelBus-1:0] EXE_RES_NOP        = 3'b000;
  localparam logic [AluSelBus-1:0] EXE_RES_LOGIC      = 3'b001;
  localparam logic [AluSelBus-1:0] EXE_RES_SHIFT      = 3'b010;
  localparam logic [AluSelBus-1:0] EXE_RES_MOVE       = 3'b011;
  localparam logic [AluSelBus-1:0] EXE_RES_ARITHMETIC = 3'b100;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'b00,
    DIV_ZERO = 2'b01,
    DIV_ON   = 2'b10,
    DIV_END  = 2'b11
  } div_state_t;

endpackage

// File: rtl/ex_div.sv
// Iterative radix-2 restoring divider (32 steps) with signed fix-up.
// Instantiated by ex only when EXE_DIV_EN is defined.
module div
  import ex_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        signed_i,
  input  logic [31:0] opdata1_i,
  input  logic [31:0] opdata2_i,
  input  logic        start_i,
  input  logic        annul_i,
  output logic [63:0] result_o,
  output logic        ready_o
);

  div_state_t  state;
  div_state_t  state_next;
  logic [31:0] quo;
  logic [31:0] rem;
  logic [31:0] dvs;
  logic [4:0]  count;
  logic        q_neg;
  logic        r_neg;
  logic [31:0] abs1;
  logic [31:0] abs2;
  logic [32:0] shifted;
  logic [33:0] diff;
  logic        borrow;
  logic [31:0] q_fix;
  logic [31:0] r_fix;

  assign abs1    = (signed_i && opdata1_i[31]) ? (~opdata1_i + 32'd1) : opdata1_i;
  assign abs2    = (signed_i && opdata2_i[31]) ? (~opdata2_i + 32'd1) : opdata2_i;
  // Partial remainder shifted left with the next dividend bit pulled in from the quotient register.
  assign shifted = {rem, quo[31]};
  assign diff    = {1'b0, shifted} - {2'b00, dvs};
  assign borrow  = diff[33];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= DIV_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    if (annul_i) begin
      state_next = DIV_IDLE;
    end else begin
      case (state)
        DIV_IDLE: begin
          if (start_i) begin
            if (opdata2_i == 32'd0) begin
              state_next = DIV_ZERO;
            end else begin
              state_next = DIV_ON;
            end
          end else begin
            state_next = DIV_IDLE;
          end
        end
        DIV_ZERO: state_next = DIV_END;
        DIV_ON: begin
          if (count == 5'd31) begin
            state_next = DIV_END;
          end else begin
            state_next = DIV_ON;
          end
        end
        DIV_END: state_next = DIV_IDLE;
        default: state_next = DIV_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      quo   <= 32'd0;
      rem   <= 32'd0;
      dvs   <= 32'd0;
      count <= 5'd0;
      q_neg <= 1'b0;
      r_neg <= 1'b0;
    end else begin
      case (state)
        DIV_IDLE: begin
          if (state_next == DIV_ON) begin
            quo   <= abs1;
            rem   <= 32'd0;
            dvs   <= abs2;
            count <= 5'd0;
            q_neg <= signed_i & (opdata1_i[31] ^ opdata2_i[31]);
            r_neg <= signed_i & opdata1_i[31];
          end
        end
        DIV_ZERO: begin
          quo   <= 32'd0;
          rem   <= 32'd0;
          q_neg <= 1'b0;
          r_neg <= 1'b0;
        end
        DIV_ON: begin
          rem   <= borrow ? shifted[31:0] : diff[31:0];
          quo   <= {quo[30:0], ~borrow};
          count <= count + 5'd1;
        end
        default: begin
          count <= count;
        end
      endcase
    end
  end

  assign q_fix    = q_neg ? (~quo + 32'd1) : quo;
  assign r_fix    = r_neg ? (~rem + 32'd1) : rem;
  assign ready_o  = (state == DIV_END);
  assign result_o = ready_o ? {r_fix, q_fix} : 64'd0;

endmodule

// File: rtl/ex.sv
// MIPS32 execute stage: logic/shift/arith/move results for EX/MEM.
// Define EXE_DIV_EN to build the iterative DIV/DIVU unit; otherwise divides are NOPs.
module ex
  import ex_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic [AluOpBus-1:0]   aluop_i,
  input  logic [AluSelBus-1:0]  alusel_i,
  input  logic [RegBus-1:0]     reg1_i,
  input  logic [RegBus-1:0]     reg2_i,
  input  logic [RegAddrBus-1:0] wd_i,
  input  logic                  wreg_i,
  input  logic [RegBus-1:0]     hi_i,
  input  logic [RegBus-1:0]     lo_i,
  input  logic                  flush_i,
  output logic [RegAddrBus-1:0] wd_o,
  output logic                  wreg_o,
  output logic [RegBus-1:0]     wdata_o,
  output logic                  whilo_o,
  output logic [RegBus-1:0]     hi_o,
  output logic [RegBus-1:0]     lo_o,
  output logic                  stallreq_o
);

  logic [RegBus-1:0] logic_res;
  logic [RegBus-1:0] shift_res;
  logic [RegBus-1:0] arith_res;
  logic [RegBus-1:0] move_res;
  logic [RegBus-1:0] sum;
  logic              is_sub;
  logic              ov;
  logic              is_div;
  logic              div_stall;
  logic              div_whilo;
  logic [RegBus-1:0] div_hi;
  logic [RegBus-1:0] div_lo;

  assign is_div = (aluop_i == EXE_DIV_OP) || (aluop_i == EXE_DIVU_OP);
  assign is_sub = (aluop_i == EXE_SUB_OP) || (aluop_i == EXE_SUBU_OP);
  assign sum    = is_sub ? (reg1_i - reg2_i) : (reg1_i + reg2_i);

  // Signed overflow only matters for the trapping forms ADD and SUB.
  always_comb begin
    ov = 1'b0;
    if (aluop_i == EXE_ADD_OP) begin
      ov = (reg1_i[31] == reg2_i[31]) && (sum[31] != reg1_i[31]);
    end else if (aluop_i == EXE_SUB_OP) begin
      ov = (reg1_i[31] != reg2_i[31]) && (sum[31] != reg1_i[31]);
    end else begin
      ov = 1'b0;
    end
  end

  always_comb begin
    logic_res = ZeroWord;
    case (aluop_i)
      EXE_AND_OP: logic_res = reg1_i & reg2_i;
      EXE_OR_OP:  logic_res = reg1_i | reg2_i;
      EXE_XOR_OP: logic_res = reg1_i ^ reg2_i;
      EXE_NOR_OP: logic_res = ~(reg1_i | reg2_i);
      default:    logic_res = ZeroWord;
    endcase
  end

  always_comb begin
    shift_res = ZeroWord;
    case (aluop_i)
      EXE_SLL_OP: shift_res = reg2_i << reg1_i[4:0];
      EXE_SRL_OP: shift_res = reg2_i >> reg1_i[4:0];
      EXE_SRA_OP: shift_res = $unsigned($signed(reg2_i) >>> reg1_i[4:0]);
      default:    shift_res = ZeroWord;
    endcase
  end

  always_comb begin
    arith_res = ZeroWord;
    case (aluop_i)
      EXE_ADD_OP, EXE_ADDU_OP, EXE_SUB_OP, EXE_SUBU_OP: arith_res = sum;
      EXE_SLT_OP:  arith_res = {31'd0, ($signed(reg1_i) < $signed(reg2_i))};
      EXE_SLTU_OP: arith_res = {31'd0, (reg1_i < reg2_i)};
      default:     arith_res = ZeroWord;
    endcase
  end

  always_comb begin
    move_res = ZeroWord;
    case (aluop_i)
      EXE_MFHI_OP: move_res = hi_i;
      EXE_MFLO_OP: move_res = lo_i;
      default:     move_res = ZeroWord;
    endcase
  end

`ifdef EXE_DIV_EN
  logic [63:0] div_result;
  logic        div_ready;

  div u_div (
    .clk       (clk),
    .rst       (rst),
    .signed_i  (aluop_i == EXE_DIV_OP),
    .opdata1_i (reg1_i),
    .opdata2_i (reg2_i),
    .start_i   (is_div & ~flush_i),
    .annul_i   (flush_i),
    .result_o  (div_result),
    .ready_o   (div_ready)
  );

  assign div_stall = is_div & ~div_ready & ~flush_i;
  assign div_whilo = is_div & div_ready;
  assign div_hi    = div_result[63:32];
  assign div_lo    = div_result[31:0];
`else
  logic unused_div_inputs;

  assign unused_div_inputs = &{1'b0, clk, flush_i};
  assign div_stall = NoStop;
  assign div_whilo = WriteDisable;
  assign div_hi    = ZeroWord;
  assign div_lo    = ZeroWord;
`endif

  // Output mux; everything is held at zero while reset is asserted.
  always_comb begin
    wd_o       = NOPRegAddr;
    wreg_o     = WriteDisable;
    wdata_o    = ZeroWord;
    whilo_o    = WriteDisable;
    hi_o       = ZeroWord;
    lo_o       = ZeroWord;
    stallreq_o = NoStop;
    if (rst) begin
      wd_o       = wd_i;
      wreg_o     = (ov || is_div) ? WriteDisable : wreg_i;
      stallreq_o = div_stall;
      case (alusel_i)
        EXE_RES_LOGIC:      wdata_o = logic_res;
        EXE_RES_SHIFT:      wdata_o = shift_res;
        EXE_RES_ARITHMETIC: wdata_o = arith_res;
        EXE_RES_MOVE:       wdata_o = move_res;
        default:            wdata_o = ZeroWord;
      endcase
      if (aluop_i == EXE_MTHI_OP) begin
        whilo_o = WriteEnable;
        hi_o    = reg1_i;
        lo_o    = lo_i;
      end else if (aluop_i == EXE_MTLO_OP) begin
        whilo_o = WriteEnable;
        hi_o    = hi_i;
        lo_o    = reg1_i;
      end else if (is_div) begin
        whilo_o = div_whilo;
        hi_o    = div_hi;
        lo_o    = div_lo;
      end else begin
        whilo_o = WriteDisable;
      end
    end else begin
      wd_o = NOPRegAddr;
    end
  end

endmodule
